// File: rtl/sr_pkg.sv
// Shared types and constants for the SR excitation driver and its helpers.
package sr_pkg;

    // Per-bit sequencing states of the driver.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } sr_state_e;

    // Excitation codes, packed as {S, R}.
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_RST  = 2'b01;

endpackage

// File: rtl/sr_excite.sv
// SR flip-flop excitation table: (present Q, wanted next Q) -> {S, R}.
// Don't-care entries resolve to HOLD, so the illegal 11 code cannot appear.
module sr_excite
    import sr_pkg::*;
(
    input  logic       q_i,
    input  logic       t_i,
    output logic [1:0] sr_o
);

    // Map the present/next pair onto the minimal legal drive.
    always_comb begin
        sr_o = SR_HOLD;
        case ({q_i, t_i})
            2'b01:   sr_o = SR_SET;
            2'b10:   sr_o = SR_RST;
            default: sr_o = SR_HOLD;
        endcase
    end

endmodule

// File: rtl/sr_excite_driver.sv
// Serializes target words (LSB first) onto a clocked SR flip-flop through
// its excitation table, then checks that Q landed on each target bit.
// Each bit uses three cycles: DRIVE (compute), SETTLE (S/R visible),
// CHECK (compare q_fb against the target).
module sr_excite_driver
    import sr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             q_fb,
    input  logic             clr_err,
    output logic             S,
    output logic             R,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [ERRW-1:0]  err_count
);

    localparam int              IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(WIDTH - 1);
    localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};

    sr_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mism_q, mism_d;
    logic [ERRW-1:0]  err_q, err_d;

    logic [1:0]       exc_s;
    logic             bit_miss_s;

    // The current target bit is always the shift register LSB.
    sr_excite u_excite (
        .q_i  (q_fb),
        .t_i  (shreg_q[0]),
        .sr_o (exc_s)
    );

    // Bit compare written as equality-else so an unknown q_fb lands on the miss branch.
    always_comb begin
        if (q_fb == shreg_q[0]) begin
            bit_miss_s = 1'b0;
        end else begin
            bit_miss_s = 1'b1;
        end
    end

    // Next-state, drive and bookkeeping logic for the bit sequencer.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        s_d     = 1'b0;
        r_d     = 1'b0;
        done_d  = 1'b0;
        mism_d  = mism_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (tgt_valid && ready_q) begin
                    shreg_d = tgt_data;
                    idx_d   = {IW{1'b0}};
                    mism_d  = 1'b0;
                    state_d = DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                s_d     = exc_s[1];
                r_d     = exc_s[0];
                state_d = SETTLE;
            end
            SETTLE: begin
                // S/R drop back to 0 on the same edge the flip-flop samples them.
                state_d = CHECK;
            end
            CHECK: begin
                if (bit_miss_s) begin
                    mism_d = 1'b1;
                end else begin
                    mism_d = mism_q;
                end
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    shreg_d = shreg_q >> 1;
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear wins over a same-cycle increment; the count sticks at its maximum.
        if (clr_err) begin
            err_d = {ERRW{1'b0}};
        end else if ((state_q == CHECK) && bit_miss_s && (err_q != ERR_MAX)) begin
            err_d = err_q + ERRW'(1);
        end else begin
            err_d = err_q;
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs; reset drops any word in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= {WIDTH{1'b0}};
            idx_q   <= {IW{1'b0}};
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mism_q  <= 1'b0;
            err_q   <= {ERRW{1'b0}};
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            r_q     <= r_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mism_q  <= mism_d;
            err_q   <= err_d;
        end
    end

    assign tgt_ready = ready_q;
    assign S         = s_q;
    assign R         = r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mismatch  = mism_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_sr_excite_driver.sv
// Directed bench: dut1 (ERRW=8) drives a behavioural SR flip-flop that can be
// switched to stuck-at-0; dut2 (ERRW=2) sees a permanently stuck-at-0 Q and
// shares all other stimulus, so its counter exercises saturation.
module tb_sr_excite_driver;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         tgt_valid = 1'b0;
    logic [W-1:0] tgt_data  = '0;
    logic         clr_err   = 1'b0;
    logic         stuck     = 1'b0;
    logic         q1        = 1'b0;
    logic         q2        = 1'b0;

    logic       tgt_ready1, s1, r1, busy1, done1, mism1;
    logic [7:0] err1;
    logic       tgt_ready2, s2, r2, busy2, done2, mism2;
    logic [1:0] err2;

    typedef struct {
        logic       m1;
        logic [7:0] e1;
        logic       m2;
        logic [1:0] e2;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   exp_err1 = 0;
    int   exp_err2 = 0;

    sr_excite_driver #(.WIDTH(W), .ERRW(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready1),
        .tgt_data(tgt_data), .q_fb(q1), .clr_err(clr_err), .S(s1), .R(r1),
        .busy(busy1), .done(done1), .mismatch(mism1), .err_count(err1)
    );

    sr_excite_driver #(.WIDTH(W), .ERRW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready2),
        .tgt_data(tgt_data), .q_fb(q2), .clr_err(clr_err), .S(s2), .R(r2),
        .busy(busy2), .done(done2), .mismatch(mism2), .err_count(err2)
    );

    always #5 clk = ~clk;

    // Behavioural SR flip-flop for dut1, optionally stuck at 0.
    always @(posedge clk) begin
        if (stuck)
            q1 <= 1'b0;
        else if (s1 && !r1)
            q1 <= 1'b1;
        else if (r1 && !s1)
            q1 <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // S and R must never be high together on either driver.
    always @(negedge clk) begin
        chk("sr_illegal_1", {31'd0, s1 & r1}, 32'd0);
        chk("sr_illegal_2", {31'd0, s2 & r2}, 32'd0);
    end

    task automatic wait_ready(output int waits);
        waits = 0;
        while (tgt_ready1 !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("tgt_ready_idle", {31'd0, tgt_ready1}, 32'd1);
    endtask

    // Offer one word at a negedge, check every cycle of it, then score done.
    task automatic send_word(input logic [W-1:0] w, input bit hold, input bit b2b, input bit clr);
        logic [1:0] pairs [W];
        logic       qp;
        int         ones;
        int         waits;
        exp_t       e;
        logic [1:0] exp_pair;

        wait_ready(waits);
        if (b2b) begin
            chk("b2b_no_gap", waits, 32'd0);
            chk("b2b_in_done", {31'd0, done1}, 32'd1);
        end

        qp   = stuck ? 1'b0 : q1;
        ones = 0;
        for (int k = 0; k < W; k++) begin
            if (!qp && w[k])
                pairs[k] = 2'b10;
            else if (qp && !w[k])
                pairs[k] = 2'b01;
            else
                pairs[k] = 2'b00;
            if (!stuck) qp = w[k];
            if (w[k]) ones++;
        end
        if (clr)        exp_err1 = 0;
        else if (stuck) exp_err1 = (exp_err1 + ones > 255) ? 255 : exp_err1 + ones;
        exp_err2 = clr ? 0 : ((exp_err2 + ones > 3) ? 3 : exp_err2 + ones);
        e.m1 = stuck && (ones > 0);
        e.e1 = exp_err1[7:0];
        e.m2 = (ones > 0);
        e.e2 = exp_err2[1:0];
        sb.push_back(e);

        tgt_valid = 1'b1;
        tgt_data  = w;
        clr_err   = clr;
        @(posedge clk);
        for (int c = 1; c <= 3 * W; c++) begin
            @(negedge clk);
            exp_pair = (c % 3 == 2) ? pairs[(c - 2) / 3] : 2'b00;
            chk("sr_drive", {30'd0, s1, r1}, {30'd0, exp_pair});
            chk("busy_word", {31'd0, busy1}, 32'd1);
            chk("ready_busy", {31'd0, tgt_ready1}, 32'd0);
            chk("done_early", {31'd0, done1}, 32'd0);
            if (c == 1) begin
                if (!hold) tgt_valid = 1'b0;
                tgt_data = ~w;
            end
        end
        @(negedge clk);
        chk("done1", {31'd0, done1}, 32'd1);
        chk("done2", {31'd0, done2}, 32'd1);
        chk("busy_after", {31'd0, busy1}, 32'd0);
        chk("ready_after", {31'd0, tgt_ready1}, 32'd1);
        chk("sb_nonempty", sb.size(), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mismatch1", {31'd0, mism1}, {31'd0, e.m1});
            chk("err_count1", {24'd0, err1}, {24'd0, e.e1});
            chk("mismatch2", {31'd0, mism2}, {31'd0, e.m2});
            chk("err_count2", {30'd0, err2}, {30'd0, e.e2});
        end
        clr_err = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_S"}, {31'd0, s1}, 32'd0);
        chk({tag, "_R"}, {31'd0, r1}, 32'd0);
        chk({tag, "_ready"}, {31'd0, tgt_ready1}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy1}, 32'd0);
        chk({tag, "_done"}, {31'd0, done1}, 32'd0);
        chk({tag, "_mism"}, {31'd0, mism1}, 32'd0);
        chk({tag, "_err1"}, {24'd0, err1}, 32'd0);
        chk({tag, "_err2"}, {30'd0, err2}, 32'd0);
    endtask

    // Start a word, reset during SETTLE of bit 3, and confirm no done follows.
    task automatic abort_word(input logic [W-1:0] w);
        int waits;
        wait_ready(waits);
        tgt_valid = 1'b1;
        tgt_data  = w;
        @(posedge clk);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) tgt_valid = 1'b0;
        end
        chk("abort_busy", {31'd0, busy1}, 32'd1);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_reset_state("abort_rst");
        end
        rst_n    = 1'b1;
        exp_err1 = 0;
        exp_err2 = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done1}, 32'd0);
            chk("abort_idle", {31'd0, busy1}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Ideal flip-flop starting from Q=0.
        stuck = 1'b0;
        send_word(8'hA5, 1'b0, 1'b0, 1'b0);
        send_word(8'h00, 1'b0, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0, 1'b0);

        // Stuck-at-0: mismatches accumulate and are not cleared by accept.
        @(negedge clk);
        stuck = 1'b1;
        send_word(8'h0F, 1'b0, 1'b0, 1'b0);
        send_word(8'h0F, 1'b0, 1'b0, 1'b0);
        // Clear held across mismatching CHECK cycles wins every time.
        send_word(8'hFF, 1'b0, 1'b0, 1'b1);

        // Back-to-back words with tgt_valid held high.
        @(negedge clk);
        stuck = 1'b0;
        send_word(8'h3C, 1'b1, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b1, 1'b0);

        // Reset mid-word, then a normal word.
        abort_word(8'h5A);
        send_word(8'h96, 1'b0, 1'b0, 1'b0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_excite_driver.md
Name: sr_excite_driver

Overview:
- Drives a clocked SR flip-flop (S, R in; Q out) so that its Q follows a target bit sequence, using the SR excitation table.
- Accepts WIDTH-bit target words over a valid/ready handshake and serializes them LSB first.
- For each bit, reads the flip-flop's Q through q_fb, emits the legal S/R pair, then checks that Q reached the target.
- Acts as stimulus generator and self-check master for SR flip-flop instances in the FlipFlops library.

Parameters:
- WIDTH, 8, bits per target word (>=1).
- ERRW, 8, width of the cumulative mismatch counter.

Ports:
- clk  input  1  rising-edge clock shared with the driven flip-flop.
- rst_n  input  1  reset, synchronous, active-low.
- tgt_valid  input  1  target word offered.
- tgt_ready  output  1  driver can accept a word.
- tgt_data  input  WIDTH  target Q sequence, bit 0 applied first.
- q_fb  input  1  Q of the driven flip-flop.
- clr_err  input  1  synchronous clear of err_count.
- S  output  1  set drive to the flip-flop.
- R  output  1  reset drive to the flip-flop.
- busy  output  1  word in progress.
- done  output  1  one-cycle pulse when a word completes.
- mismatch  output  1  last word had at least one Q mismatch; valid from done onward.
- err_count  output  ERRW  cumulative mismatched bits, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; S=R=0; tgt_ready=1 on the following cycle.
  - busy=0, done=0, mismatch=0, err_count=0.
  - Any in-flight word is discarded and no done pulse is produced.
- FSM states: IDLE, DRIVE, SETTLE, CHECK. Each bit takes 3 cycles (DRIVE, SETTLE, CHECK).
- IDLE:
  - tgt_ready=1, busy=0.
  - On tgt_valid&tgt_ready: latch tgt_data into a shift register, clear bit index, clear mismatch, go to DRIVE.
  - Words are accepted only in IDLE.
- DRIVE:
  - Compute excitation from (q_fb, target bit) and register it into S/R: 0->0: 00; 0->1: S=1; 1->0: R=1; 1->1: 00.
  - Don't-care entries are always driven as 0.
  - Go to SETTLE.
- SETTLE:
  - S/R are visible only in this state.
  - The flip-flop samples them at the edge ending SETTLE.
  - S/R are registered to 0 at that same edge; go to CHECK.
- CHECK:
  - S=R=0.
  - If q_fb != target bit: set mismatch and increment err_count.
  - If this was the last bit (index WIDTH-1): go to IDLE and pulse done in the next cycle (first IDLE cycle). Otherwise advance the index and go to DRIVE.
- Latency: done is high exactly 3*WIDTH+1 cycles after the accept edge. Back-to-back words are possible: the next accept can occur in the same cycle done is high.
- busy=1 in DRIVE, SETTLE and CHECK.
- Invariant: S&R==0 in every cycle; the invalid 11 combination is never driven.
- err_count:
  - Saturates at 2^ERRW-1.
  - clr_err zeroes it at the next edge and takes priority over a simultaneous increment.
  - It is not cleared by word accept.
- q_fb unknown or X in CHECK counts as a mismatch.
- tgt_data is ignored outside an accept cycle.

Decomposition:
- Package sr_pkg:
  - State enum (IDLE/DRIVE/SETTLE/CHECK).
  - 2-bit excitation constants SR_HOLD=00, SR_SET=10, SR_RST=01.
- Sub-module sr_excite: combinational (q, target) -> {S,R} function, instantiated once. It is reusable by JK/T excitation drivers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-activity. Then S=R=0, tgt_ready=1, busy=0, done=0, err_count=0.
- Ideal SRFF model, Q=0, word 8'hA5: S pulses in the SETTLE cycles of bits 0, 2, 5, 7; R pulses in the SETTLE cycles of bits 1, 3, 6. done comes 25 cycles after accept; mismatch=0; S&R never 1.
- Ideal model, Q=0, word 8'hFF: S pulses only for bit 0; bits 1-7 drive 00. mismatch=0.
- Stuck-at-0 model, word 8'h0F: mismatch=1, err_count=4. Repeat the word: err_count=8.
  - With ERRW=2: err_count saturates at 3.
  - With clr_err and a mismatch in the same cycle: err_count=0.
- Hold tgt_valid=1 with two different words: the second is accepted in the done cycle, with no idle gap. tgt_ready=0 throughout busy.
- Assert rst_n=0 during SETTLE of bit 3: next cycle IDLE, S=R=0, no done pulse; a new word is then processed normally.
